// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module  : instr_fetch_unit
// Brief   : Fetch stage with 1-cycle imem, 2-entry output FIFO, stall/redirect
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INS  = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] ins_o,
    output logic [31:0] pc_id_o,
    output logic        ins_valid_o,
    output logic        fetch_fault_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_REDIR = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q;
    logic        inflight_q;
    logic [1:0]  count_q, count_d;
    logic [31:0] head_ins_q, head_ins_d, head_pc_q, head_pc_d;
    logic [31:0] tail_ins_q, tail_ins_d, tail_pc_q, tail_pc_d;

    logic        w_redir_ok;
    logic        w_pop;
    logic        w_push;
    logic [2:0]  w_occupancy;

    assign w_redir_ok  = redirect_i & (redirect_pc_i[1:0] == 2'b00);
    assign ins_valid_o = (count_q != 2'd0);
    assign w_pop       = ins_valid_o & ~stall_i & ~redirect_i;
    // A word returning in a redirect cycle is wrong-path and is dropped.
    assign w_push      = inflight_q & ~redirect_i;
    assign w_occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, w_pop};

    assign imem_addr_o   = pc_q;
    assign ins_o         = ins_valid_o ? head_ins_q : NOP_INS;
    assign pc_id_o       = head_pc_q;
    assign fetch_fault_o = (state_q == ST_FAULT);

    // Next state and request issue
    always_comb begin
        state_d    = state_q;
        imem_req_o = 1'b0;
        if (redirect_i) begin
            state_d = w_redir_ok ? ST_REDIR : ST_FAULT;
        end else if (state_q == ST_REDIR) begin
            state_d = ST_RUN;
        end
        if (!rst_i && state_q == ST_RUN && !redirect_i && w_occupancy < 3'd2) begin
            imem_req_o = 1'b1;
        end
    end

    // Fetch PC and FIFO datapath
    always_comb begin
        pc_d       = pc_q;
        count_d    = count_q;
        head_ins_d = head_ins_q;
        head_pc_d  = head_pc_q;
        tail_ins_d = tail_ins_q;
        tail_pc_d  = tail_pc_q;

        if (w_redir_ok) begin
            pc_d = redirect_pc_i;
        end else if (imem_req_o) begin
            pc_d = pc_q + 32'd4;
        end

        if (redirect_i) begin
            count_d = 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_ins_d = imem_rdata_i;
                        head_pc_d  = req_pc_q;
                    end else begin
                        head_ins_d = tail_ins_q;
                        head_pc_d  = tail_pc_q;
                        tail_ins_d = imem_rdata_i;
                        tail_pc_d  = req_pc_q;
                    end
                end
                2'b01: begin
                    // Popping the last entry leaves the head untouched so PC_ID holds.
                    if (count_q == 2'd2) begin
                        head_ins_d = tail_ins_q;
                        head_pc_d  = tail_pc_q;
                    end
                    count_d = count_q - 2'd1;
                end
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_ins_d = imem_rdata_i;
                        head_pc_d  = req_pc_q;
                    end else begin
                        tail_ins_d = imem_rdata_i;
                        tail_pc_d  = req_pc_q;
                    end
                    count_d = count_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            req_pc_q   <= 32'd0;
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            head_ins_q <= 32'd0;
            head_pc_q  <= 32'd0;
            tail_ins_q <= 32'd0;
            tail_pc_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= imem_req_o;
            if (imem_req_o) begin
                req_pc_q <= pc_q;
            end
            count_q    <= count_d;
            head_ins_q <= head_ins_d;
            head_pc_q  <= head_pc_d;
            tail_ins_q <= tail_ins_d;
            tail_pc_q  <= tail_pc_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module  : tb_instr_fetch_unit
// Brief   : Directed vector table plus randomized run against a queue model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

    localparam logic [31:0] K_XOR = 32'hA5A5_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int M_RUN   = 0;
    localparam int M_REDIR = 1;
    localparam int M_FAULT = 2;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pcid;
        logic        fault;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] ins;
    logic [31:0] pc_id;
    logic        ins_valid;
    logic        fetch_fault;

    int n_checks;
    int n_errors;
    int cyc;

    instr_fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .NOP_INS (32'h0000_0013)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .imem_rdata_i (imem_rdata),
        .stall_i      (stall),
        .redirect_i   (redir),
        .redirect_pc_i(rpc),
        .ins_o        (ins),
        .pc_id_o      (pc_id),
        .ins_valid_o  (ins_valid),
        .fetch_fault_o(fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory with a recognisable address pattern
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (imem_req) imem_rdata <= imem_addr ^ K_XOR;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic vec_t v(input logic r, input logic s, input logic d, input logic [31:0] p,
                               input logic q, input logic [31:0] a, input logic vl,
                               input logic [31:0] pc, input logic f);
        vec_t t;
        t.rst = r; t.stall = s; t.redir = d; t.rpc = p;
        t.req = q; t.addr = a; t.valid = vl; t.pcid = pc; t.fault = f;
        return t;
    endfunction

    task automatic apply_vec(input vec_t t);
        @(negedge clk);
        rst = t.rst; stall = t.stall; redir = t.redir; rpc = t.rpc;
        #1;
        chk("imem_req", {31'd0, imem_req}, {31'd0, t.req});
        if (t.req) chk("imem_addr", imem_addr, t.addr);
        chk("ins_valid", {31'd0, ins_valid}, {31'd0, t.valid});
        chk("ins", ins, t.valid ? (t.pcid ^ K_XOR) : NOP);
        chk("pc_id", pc_id, t.pcid);
        chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, t.fault});
    endtask

    // Reference model state: FIFO and in-flight request as queues of PCs
    logic [31:0] m_fifo[$];
    logic [31:0] m_infl[$];
    logic [31:0] m_pc;
    logic [31:0] m_last_pc;
    int          m_mode;

    task automatic model_reset();
        m_fifo.delete(); m_infl.delete();
        m_pc = 32'h0; m_last_pc = 32'h0; m_mode = M_RUN;
    endtask

    task automatic random_cycle();
        logic        m_valid, m_pop, m_req;
        logic [31:0] m_pcid, tmp;
        int          r;
        @(negedge clk);
        rst   = ($urandom_range(0, 299) == 0);
        stall = ($urandom_range(0, 99) < 35);
        redir = ($urandom_range(0, 99) < 6);
        r     = $urandom_range(0, 9);
        tmp   = $urandom();
        if (r == 0)      rpc = {tmp[31:2], 2'b00} | 32'd1 + {30'd0, tmp[1:0] & 2'b01, 1'b0};
        else if (r == 1) rpc = 32'hFFFF_FFF0 + 32'd4 * $urandom_range(0, 3);
        else             rpc = {16'd0, tmp[15:2], 2'b00};
        #1;
        m_valid = (m_fifo.size() != 0);
        m_pcid  = m_valid ? m_fifo[0] : m_last_pc;
        m_pop   = m_valid && !stall && !redir;
        m_req   = !rst && m_mode == M_RUN && !redir &&
                  (m_fifo.size() + m_infl.size() - int'(m_pop) < 2);
        chk("rnd imem_req", {31'd0, imem_req}, {31'd0, m_req});
        if (m_req) chk("rnd imem_addr", imem_addr, m_pc);
        chk("rnd ins_valid", {31'd0, ins_valid}, {31'd0, m_valid});
        chk("rnd ins", ins, m_valid ? (m_pcid ^ K_XOR) : NOP);
        chk("rnd pc_id", pc_id, m_pcid);
        chk("rnd fetch_fault", {31'd0, fetch_fault}, {31'd0, (m_mode == M_FAULT)});
        if (rst) begin
            model_reset();
        end else begin
            m_last_pc = m_pcid;
            if (redir) begin
                m_fifo.delete();
                m_infl.delete();
            end else begin
                if (m_pop) void'(m_fifo.pop_front());
                if (m_infl.size() != 0) m_fifo.push_back(m_infl.pop_front());
            end
            if (m_req) begin
                m_infl.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
            if (redir) begin
                if (rpc[1:0] == 2'b00) begin
                    m_pc   = rpc;
                    m_mode = M_REDIR;
                end else begin
                    m_mode = M_FAULT;
                end
            end else if (m_mode == M_REDIR) begin
                m_mode = M_RUN;
            end
        end
    endtask

    vec_t tbl[$];

    initial begin
        n_checks = 0; n_errors = 0; cyc = 0;
        rst = 1'b1; stall = 1'b0; redir = 1'b0; rpc = 32'h0;
        imem_rdata = 32'h0;
        repeat (2) @(posedge clk);

        // Start-up stream, stall, redirect over full FIFO, redirect+stall
        tbl.push_back(v(1,0,0,32'h0,        0,32'h0,  0,32'h0,  0));
        tbl.push_back(v(0,0,0,32'h0,        1,32'h0,  0,32'h0,  0));
        tbl.push_back(v(0,0,0,32'h0,        1,32'h4,  0,32'h0,  0));
        tbl.push_back(v(0,0,0,32'h0,        1,32'h8,  1,32'h0,  0));
        tbl.push_back(v(0,0,0,32'h0,        1,32'hC,  1,32'h4,  0));
        tbl.push_back(v(0,1,0,32'h0,        0,32'h0,  1,32'h8,  0));
        tbl.push_back(v(0,1,0,32'h0,        0,32'h0,  1,32'h8,  0));
        tbl.push_back(v(0,1,0,32'h0,        0,32'h0,  1,32'h8,  0));
        tbl.push_back(v(0,0,0,32'h0,        1,32'h10, 1,32'h8,  0));
        tbl.push_back(v(0,0,0,32'h0,        1,32'h14, 1,32'hC,  0));
        tbl.push_back(v(0,0,0,32'h0,        1,32'h18, 1,32'h10, 0));
        tbl.push_back(v(0,1,0,32'h0,        0,32'h0,  1,32'h14, 0));
        tbl.push_back(v(0,0,1,32'h100,      0,32'h0,  1,32'h14, 0));
        tbl.push_back(v(0,0,0,32'h0,        0,32'h0,  0,32'h14, 0));
        tbl.push_back(v(0,0,0,32'h0,        1,32'h100,0,32'h14, 0));
        tbl.push_back(v(0,0,0,32'h0,        1,32'h104,0,32'h14, 0));
        tbl.push_back(v(0,0,0,32'h0,        1,32'h108,1,32'h100,0));
        tbl.push_back(v(0,0,0,32'h0,        1,32'h10C,1,32'h104,0));
        tbl.push_back(v(0,1,1,32'h40,       0,32'h0,  1,32'h108,0));
        tbl.push_back(v(0,1,0,32'h0,        0,32'h0,  0,32'h108,0));
        tbl.push_back(v(0,1,0,32'h0,        1,32'h40, 0,32'h108,0));
        tbl.push_back(v(0,1,0,32'h0,        1,32'h44, 0,32'h108,0));
        tbl.push_back(v(0,1,0,32'h0,        0,32'h0,  1,32'h40, 0));
        tbl.push_back(v(0,0,0,32'h0,        1,32'h48, 1,32'h40, 0));
        tbl.push_back(v(0,0,0,32'h0,        1,32'h4C, 1,32'h44, 0));
        // Misaligned redirect: halted for 10 cycles, aligned redirect recovers
        tbl.push_back(v(0,0,1,32'h102,      0,32'h0,  1,32'h48, 0));
        for (int i = 0; i < 10; i++)
            tbl.push_back(v(0,0,0,32'h0,    0,32'h0,  0,32'h48, 1));
        tbl.push_back(v(0,0,1,32'h200,      0,32'h0,  0,32'h48, 1));
        tbl.push_back(v(0,0,0,32'h0,        0,32'h0,  0,32'h48, 0));
        tbl.push_back(v(0,0,0,32'h0,        1,32'h200,0,32'h48, 0));
        tbl.push_back(v(0,0,0,32'h0,        1,32'h204,0,32'h48, 0));
        tbl.push_back(v(0,0,0,32'h0,        1,32'h208,1,32'h200,0));
        // Address wrap, then reset mid-stream
        tbl.push_back(v(0,0,1,32'hFFFF_FFF8,0,32'h0,  1,32'h204,0));
        tbl.push_back(v(0,0,0,32'h0,        0,32'h0,  0,32'h204,0));
        tbl.push_back(v(0,0,0,32'h0,        1,32'hFFFF_FFF8,0,32'h204,0));
        tbl.push_back(v(0,0,0,32'h0,        1,32'hFFFF_FFFC,0,32'h204,0));
        tbl.push_back(v(0,0,0,32'h0,        1,32'h0,  1,32'hFFFF_FFF8,0));
        tbl.push_back(v(0,0,0,32'h0,        1,32'h4,  1,32'hFFFF_FFFC,0));
        tbl.push_back(v(0,0,0,32'h0,        1,32'h8,  1,32'h0,  0));
        tbl.push_back(v(1,0,0,32'h0,        0,32'h0,  1,32'h4,  0));
        tbl.push_back(v(1,0,0,32'h0,        0,32'h0,  0,32'h0,  0));
        tbl.push_back(v(0,0,0,32'h0,        1,32'h0,  0,32'h0,  0));
        tbl.push_back(v(0,0,0,32'h0,        1,32'h4,  0,32'h0,  0));
        tbl.push_back(v(0,0,0,32'h0,        1,32'h8,  1,32'h0,  0));
        foreach (tbl[i]) apply_vec(tbl[i]);

        // Back-to-back redirects; the word returning during the first is killed
        apply_vec(v(1,0,0,32'h0,   0,32'h0,   1,32'h4,   0));
        apply_vec(v(1,0,0,32'h0,   0,32'h0,   0,32'h0,   0));
        apply_vec(v(0,0,0,32'h0,   1,32'h0,   0,32'h0,   0));
        apply_vec(v(0,0,1,32'h300, 0,32'h0,   0,32'h0,   0));
        apply_vec(v(0,0,1,32'h380, 0,32'h0,   0,32'h0,   0));
        apply_vec(v(0,0,0,32'h0,   0,32'h0,   0,32'h0,   0));
        apply_vec(v(0,0,0,32'h0,   1,32'h380, 0,32'h0,   0));
        apply_vec(v(0,0,0,32'h0,   1,32'h384, 0,32'h0,   0));
        apply_vec(v(0,0,0,32'h0,   1,32'h388, 1,32'h380, 0));
        apply_vec(v(0,0,0,32'h0,   1,32'h38C, 1,32'h384, 0));

        // Randomized run against the queue model
        @(negedge clk);
        rst = 1'b1; stall = 1'b0; redir = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        for (int i = 0; i < 3000; i++) random_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
